frame_ram_arbiter: RTL and testbench

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

---
 rtl/frame_ram_arbiter_pkg.sv | 16 +
 rtl/frame_ram_arbiter_if.sv | 26 ++
 rtl/frame_ram_arbiter_starve_counter.sv | 27 ++
 rtl/frame_ram_arbiter.sv | 119 +++++++++++
 tb/tb_frame_ram_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_ram_arbiter_pkg.sv
// Shared frame-buffer RAM geometry and arbiter state encoding.
package frame_buffer_pkg;

  localparam int RAM_WIDTH = 32;
  localparam int RAM_DEPTH = (480 * 360 * 24) / RAM_WIDTH;
  localparam int ADDR_BITS = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    DONE
  } arb_state_t;

endpackage

// File: rtl/frame_ram_arbiter_if.sv
// Requester-side read/write handshake bundle for the frame RAM arbiter.
interface frame_ram_arbiter_if #(
  parameter int ADDR_BITS = frame_buffer_pkg::ADDR_BITS,
  parameter int RAM_WIDTH = frame_buffer_pkg::RAM_WIDTH
);

  logic                 rd_req;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_valid;
  logic [RAM_WIDTH-1:0] rd_data;
  logic                 wr_req;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [RAM_WIDTH-1:0] wr_data;
  logic                 wr_ack;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_valid, rd_data, wr_ack
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_valid, rd_data, wr_ack
  );

endinterface

// File: rtl/frame_ram_arbiter_starve_counter.sv
// Saturating counter of cycles a pending write has been passed over.
module starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt >= LIMIT_C);

endmodule

// File: rtl/frame_ram_arbiter.sv
// Arbitrates one reader and one writer onto a single-port synchronous frame RAM.
module frame_ram_arbiter
  import frame_buffer_pkg::*;
#(
  parameter int RAM_WIDTH    = frame_buffer_pkg::RAM_WIDTH,
  parameter int RAM_DEPTH    = (480 * 360 * 24) / RAM_WIDTH,
  parameter int STARVE_LIMIT = 8,
  localparam int ADDR_BITS   = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  frame_ram_arbiter_if.slave   bus,
  output logic                 err_sticky,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  input  logic [RAM_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_BITS:0] DEPTH_L = RAM_DEPTH[ADDR_BITS:0];

  arb_state_t state, state_d;

  logic                 rd_valid_d, wr_ack_d, ram_en_d, ram_we_d, err_d;
  logic                 rd_oor, rd_oor_d;
  logic [ADDR_BITS-1:0] ram_addr_d;
  logic [RAM_WIDTH-1:0] ram_wdata_d, rd_data_d;
  logic                 rd_req_oor, wr_req_oor, starve_sat, wr_enter;

  assign rd_req_oor = ({1'b0, bus.rd_addr} >= DEPTH_L);
  assign wr_req_oor = ({1'b0, bus.wr_addr} >= DEPTH_L);
  assign wr_enter   = (state == IDLE) && (state_d == WR_ISSUE);

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (bus.wr_req && !wr_enter),
    .clr (!bus.wr_req || wr_enter),
    .sat (starve_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Every output is computed one cycle early here so that all of them come straight from flops.
  always_comb begin
    state_d     = state;
    rd_valid_d  = 1'b0;
    wr_ack_d    = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    rd_data_d   = bus.rd_data;
    err_d       = err_sticky;
    rd_oor_d    = rd_oor;
    unique case (state)
      IDLE: begin
        if (bus.rd_req && !(bus.wr_req && starve_sat)) begin
          state_d    = RD_ISSUE;
          ram_addr_d = bus.rd_addr;
          rd_oor_d   = rd_req_oor;
          ram_en_d   = !rd_req_oor;
          err_d      = err_sticky || rd_req_oor;
        end else if (bus.wr_req) begin
          state_d     = WR_ISSUE;
          ram_addr_d  = bus.wr_addr;
          ram_wdata_d = bus.wr_data;
          ram_en_d    = !wr_req_oor;
          ram_we_d    = !wr_req_oor;
          err_d       = err_sticky || wr_req_oor;
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        state_d    = DONE;
        rd_valid_d = 1'b1;
        rd_data_d  = rd_oor ? '0 : ram_rdata;
      end
      WR_ISSUE: begin
        state_d  = DONE;
        wr_ack_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
      bus.wr_ack   <= 1'b0;
      err_sticky   <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      rd_oor       <= 1'b0;
    end else begin
      bus.rd_valid <= rd_valid_d;
      bus.rd_data  <= rd_data_d;
      bus.wr_ack   <= wr_ack_d;
      err_sticky   <= err_d;
      ram_en       <= ram_en_d;
      ram_we       <= ram_we_d;
      ram_addr     <= ram_addr_d;
      ram_wdata    <= ram_wdata_d;
      rd_oor       <= rd_oor_d;
    end
  end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed and randomized transactions checked against a transaction-level memory model.
module tb_frame_ram_arbiter;
  import frame_buffer_pkg::*;

  localparam int STARVE = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 err_sticky, ram_en, ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [RAM_WIDTH-1:0] ram_wdata;
  logic [RAM_WIDTH-1:0] ram_rdata = '0;

  frame_ram_arbiter_if #(.ADDR_BITS(ADDR_BITS), .RAM_WIDTH(RAM_WIDTH)) bus ();

  frame_ram_arbiter #(.RAM_WIDTH(RAM_WIDTH), .RAM_DEPTH(RAM_DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_sticky (err_sticky),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  // Single-port RAM with one-cycle read latency; unwritten words read their initial pattern.
  logic [31:0] ram_mem [RAM_DEPTH];
  bit          ram_wr  [RAM_DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[int'(ram_addr)] <= ram_wdata;
        ram_wr[int'(ram_addr)]  <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[int'(ram_addr)] ? ram_mem[int'(ram_addr)] : init_val(int'(ram_addr));
      end
    end
  end

  logic [31:0] ref_mem [int];
  bit          ref_err;
  logic [31:0] exp_rd_data;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] ref_read(input int a);
    if (a >= RAM_DEPTH) return '0;
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int a);
    bit oor;
    oor = (a >= RAM_DEPTH);
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_BITS'(a);
    tick();
    chk("rd_t1_en", ram_en, !oor);
    chk("rd_t1_we", ram_we, 0);
    if (!oor) chk("rd_t1_addr", ram_addr, a);
    chk("rd_t1_valid", bus.rd_valid, 0);
    tick();
    chk("rd_t2_en", ram_en, 0);
    chk("rd_t2_valid", bus.rd_valid, 0);
    tick();
    ref_err     = ref_err | oor;
    exp_rd_data = ref_read(a);
    chk("rd_t3_valid", bus.rd_valid, 1);
    chk("rd_t3_data", bus.rd_data, exp_rd_data);
    chk("rd_t3_ack", bus.wr_ack, 0);
    chk("rd_t3_err", err_sticky, ref_err);
    bus.rd_req = 1'b0;
    tick();
    chk("rd_t4_valid", bus.rd_valid, 0);
    chk("rd_t4_hold", bus.rd_data, exp_rd_data);
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    bit oor;
    oor = (a >= RAM_DEPTH);
    bus.wr_req  = 1'b1;
    bus.wr_addr = ADDR_BITS'(a);
    bus.wr_data = d;
    tick();
    chk("wr_t1_en", ram_en, !oor);
    chk("wr_t1_we", ram_we, !oor);
    if (!oor) begin
      chk("wr_t1_addr", ram_addr, a);
      chk("wr_t1_wdata", ram_wdata, d);
    end
    chk("wr_t1_ack", bus.wr_ack, 0);
    tick();
    ref_err = ref_err | oor;
    if (!oor) ref_mem[a] = d;
    chk("wr_t2_ack", bus.wr_ack, 1);
    chk("wr_t2_valid", bus.rd_valid, 0);
    chk("wr_t2_en", ram_en, 0);
    chk("wr_t2_err", err_sticky, ref_err);
    bus.wr_req = 1'b0;
    tick();
    chk("wr_t3_ack", bus.wr_ack, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, bus.rd_valid, 0);
    chk({tag, "_rdata"}, bus.rd_data, 0);
    chk({tag, "_ack"}, bus.wr_ack, 0);
    chk({tag, "_err"}, err_sticky, 0);
    chk({tag, "_en"}, ram_en, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_wdata"}, ram_wdata, 0);
  endtask

  initial begin
    int ra, wa, nreads, first_rd, ack_at;
    logic [31:0] wd;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    ref_err = 1'b0;
    exp_rd_data = '0;
    rst = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    do_read(5);
    do_write(100, 32'h00A5A5A5);
    do_read(100);

    // Contention: both held; reads win until the writer has waited STARVE cycles.
    ra = int'($urandom_range(0, 63));
    wa = int'($urandom_range(64, 127));
    wd = $urandom;
    bus.rd_req = 1'b1; bus.rd_addr = ADDR_BITS'(ra);
    bus.wr_req = 1'b1; bus.wr_addr = ADDR_BITS'(wa); bus.wr_data = wd;
    nreads = 0; first_rd = -1; ack_at = -1;
    for (int c = 1; c <= 40 && ack_at < 0; c++) begin
      tick();
      chk("cont_excl", bus.rd_valid & bus.wr_ack, 0);
      if (bus.rd_valid) begin
        nreads++;
        if (first_rd < 0) first_rd = c;
        chk("cont_rd_data", bus.rd_data, ref_read(ra));
      end
      if (bus.wr_ack) ack_at = c;
    end
    bus.rd_req = 1'b0; bus.wr_req = 1'b0;
    if (ack_at >= 0) ref_mem[wa] = wd;
    chk("cont_first_rd", first_rd, 3);
    chk("cont_nreads", nreads, (STARVE + 3) / 4);
    chk("cont_ack_cycle", ack_at, 4 * ((STARVE + 3) / 4) + 2);
    tick();
    do_read(wa);

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0: do_write(int'($urandom_range(0, 63)), $urandom);
        1: do_read(int'($urandom_range(0, 63)));
        default: repeat ($urandom_range(1, 3)) tick();
      endcase
    end

    do_write(129600, 32'h12345678);
    do_read(131071);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("oor_idle_en", ram_en, 0);
      chk("oor_idle_err", err_sticky, 1);
    end

    // Reset asserted during RD_CAPTURE must abort the read.
    bus.rd_req = 1'b1; bus.rd_addr = ADDR_BITS'(7);
    tick();
    chk("rstrd_t1_en", ram_en, 1);
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("rstrd");
    rst = 1'b0; bus.rd_req = 1'b0;
    ref_err = 1'b0;
    tick();
    chk("rstrd_after_valid", bus.rd_valid, 0);
    do_read(7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
